aes_key_store: RTL and testbench
================================

# aes_key_store

Expands an AES-128 cipher key into all eleven round keys and holds them in a register file indexed by round number. Sits directly upstream of the decipher round engine. The engine requests keys in descending order, from Nr down to 0, so every key must exist before decryption starts. A one-cycle registered read port returns the key for the `round_no` the engine drives.

## Interface
- `Nk`, 4: key length in 32-bit words; also the width of `round_no`.
- `Nr`, 10: number of rounds; slots 0..Nr are stored.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `key_en`  in  1  single-cycle pulse; start expansion of `key`.
- `key`  in  `KEY_S` (128)  cipher key, sampled on `key_en`.
- `round_no`  in  `Nk`  read index, 0..Nr.
- `round_key`  out  `KEY_S`  registered round key for the sampled `round_no`.
- `busy`  out  1  expansion in progress.
- `key_ready`  out  1  all Nr+1 slots valid for the current key.
- `key_clear`  in  1  zeroize request; present only with `AES_KEY_STORE_ZEROIZE_EN`.

## Operation
- **States.**
  - IDLE: `busy` = 0.
  - EXPAND: `busy` = 1, counter `cnt` runs 1..Nr.
- **IDLE → EXPAND** when `key_en` = 1.
  - slot[0] <= `key`.
  - prev <= `key`.
  - `cnt` <= 1.
  - `key_ready` <= 0.
- **EXPAND, each cycle.**
  - slot[cnt] <= next_key(prev, rcon[cnt-1]).
  - prev <= that value.
  - `cnt` <= cnt+1.
- **EXPAND → IDLE** on the cycle that writes `cnt` = Nr.
  - `busy` <= 0.
  - `key_ready` <= 1.
- **next_key** is the standard FIPS-197 step:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,00,00,00}.
  - wi' = wi ^ w(i-1)' for i = 1..3.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- Byte and word ordering follow the shared `get_byte`/`get_word` convention. FIPS-197 key byte 0 maps to block byte 0.
- **Read port.** Every cycle, `round_key` <= slot[round_no]. This happens regardless of state.
  - `round_no` > Nr returns all zeros.
  - A read during EXPAND returns whatever the slot currently holds. `key_ready` qualifies validity.
- **`key_en` while `busy` = 1:** ignored, no restart.
- **`key_en` in IDLE with `key_ready` = 1:** re-key.
  - `key_ready` drops on the next edge.
  - Old slots are overwritten progressively.
- **Reset, including mid-expansion:**
  - state <= IDLE, `busy` = 0, `key_ready` = 0, `round_key` = 0, `cnt` = 0.
  - Slot contents are not reset.
  - With `AES_KEY_STORE_ZEROIZE_EN`, reset also zeroizes all slots.

## Timing
- `key_en` sampled at edge T: slot[0] written at T.
- slot[i] written at edge T+i.
- `busy` high from after T until after T+Nr.
- `key_ready` high after edge T+Nr, i.e. 10 cycles after `key_en` for AES-128.
- Read latency: `round_no` sampled at edge E, `round_key` valid after E. This matches the engine's one-cycle key-request-to-use spacing.
- A read of slot[i] at the same edge slot[i] is written returns the old value (read-before-write).
- Throughput: one round key per cycle. No backpressure.

## Configuration
- Macro: `AES_KEY_STORE_ZEROIZE_EN`.
- **Defined:**
  - Adds the `key_clear` port.
  - `key_clear` = 1 at an edge: all slots <= 0, prev <= 0, state <= IDLE, `busy` <= 0, `key_ready` <= 0, `round_key` <= 0.
  - `key_clear` has priority over `key_en` and over an expansion in progress.
  - Reset also zeroizes all slots.
- **Undefined:**
  - No `key_clear` port.
  - Slots hold their value through reset.
  - There is no zeroize path.

## Structure
- **Shared package (`aes.vh` / `aes_common.vh`)** holds:
  - `BLK_S`, `KEY_S`, `WORD_S`, `BYTE_S`, `Nk`, `Nr`.
  - The forward S-box table and `get_sbox`.
  - The rcon table.
  - `get_byte`/`get_word`.
- **Sub-module `aes_key_round`:** purely combinational. Inputs: prev key (128) and rcon (8). Output: next round key (128). It contains RotWord, SubWord and the XOR chain.
- The top level holds the FSM, `cnt`, the slot array (Nr+1 × 128) and the read register.

## Test plan
- **FIPS-197 expansion.** Reset, then `key_en` with key 2b7e151628aed2a6abf7158809cf4f3c.
  - `key_ready` rises exactly 10 cycles later.
  - `round_no` = 1 → a0fafe1788542cb123a339392a6c7605.
  - `round_no` = 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `round_no` = 0 → the key itself.
- **Descending read sweep.** Drive `round_no` 10..0 on consecutive cycles. Each `round_key` matches the FIPS-197 schedule one cycle later.
- **Ignored `key_en`.** Pulse `key_en` with key 000102030405060708090a0b0c0d0e0f at cycle T+4 of an expansion in progress. Expansion is unaffected and round 10 still equals d014f9a8…0ca6.
- **Reset mid-operation.** Assert `reset` at T+5.
  - `busy` = 0, `key_ready` = 0, `round_key` = 0 after the edge.
  - A new `key_en` then completes normally in 10 cycles.
- **Out-of-range read.** `round_no` = 11 and `round_no` = 15 return 0.
- **Zeroize (`AES_KEY_STORE_ZEROIZE_EN` defined).** Assert `key_clear` after `key_ready`.
  - `key_ready` = 0.
  - Reads of every `round_no` 0..10 return 0.
  - `key_clear` applied together with `key_en` leaves the block IDLE.

Source files
------------

// File: rtl/aes_key_store_pkg.sv
// aes_key_store_pkg: shared AES-128 constants and helpers for the key store.
//   - Sizes:    BLK_S, KEY_S, WORD_S, BYTE_S, Nk, Nr, LAST_RND
//   - Tables:   forward S-box (SBOX_TBL), round constants (RCON_TBL)
//   - Helpers:  get_sbox, get_rcon, get_byte, get_word
// Byte/word ordering: block byte 0 (FIPS-197 key byte 0) is the most
// significant byte of a 128-bit vector, so hex literals read in FIPS order.
package aes_key_store_pkg;

    localparam int BLK_S  = 128;
    localparam int KEY_S  = 128;
    localparam int WORD_S = 32;
    localparam int BYTE_S = 8;
    localparam int Nk     = 4;
    localparam int Nr     = 10;

    // Highest valid round index, sized to the read-index width.
    localparam logic [Nk-1:0] LAST_RND = Nk'(Nr);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

    function automatic logic [BYTE_S-1:0] get_sbox(input logic [BYTE_S-1:0] b);
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    // Round constant for expansion step idx (0-based); out of range gives 0.
    function automatic logic [BYTE_S-1:0] get_rcon(input logic [Nk-1:0] idx);
        if (int'(idx) < Nr)
            return RCON_TBL[79 - 8*int'(idx) -: 8];
        return '0;
    endfunction

    function automatic logic [BYTE_S-1:0] get_byte(input logic [BLK_S-1:0] blk,
                                                   input int idx);
        return blk[BLK_S-1 - BYTE_S*idx -: BYTE_S];
    endfunction

    function automatic logic [WORD_S-1:0] get_word(input logic [BLK_S-1:0] blk,
                                                   input int idx);
        return blk[BLK_S-1 - WORD_S*idx -: WORD_S];
    endfunction

endpackage

// File: rtl/aes_key_store_key_round.sv
// aes_key_round: one combinational AES-128 key-schedule step.
//   prev_key (in,  KEY_S) : previous round key
//   rcon     (in,  8)     : round constant for this step
//   next_key (out, KEY_S) : following round key
module aes_key_round
    import aes_key_store_pkg::*;
(
    input  logic [KEY_S-1:0]  prev_key,
    input  logic [BYTE_S-1:0] rcon,
    output logic [KEY_S-1:0]  next_key
);

    logic [WORD_S-1:0] w0, w1, w2, w3;
    logic [WORD_S-1:0] rot, sub;
    logic [WORD_S-1:0] n0, n1, n2, n3;

    always_comb begin
        w0 = get_word(prev_key, 0);
        w1 = get_word(prev_key, 1);
        w2 = get_word(prev_key, 2);
        w3 = get_word(prev_key, 3);
        rot = {w3[23:0], w3[31:24]};
        sub = {get_sbox(rot[31:24]), get_sbox(rot[23:16]),
               get_sbox(rot[15:8]),  get_sbox(rot[7:0])};
        n0 = w0 ^ sub ^ {rcon, 24'h000000};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_store.sv
// aes_key_store: expands an AES-128 key into round keys 0..Nr, stores them,
// and serves them through a one-cycle registered read port.
//   clk, reset  : clock, synchronous active-high reset
//   key_en      : one-cycle pulse starting expansion of key (ignored while busy)
//   key         : cipher key, sampled with key_en
//   round_no    : read index; values above Nr read as zero
//   round_key   : registered slot[round_no]
//   busy        : expansion in progress
//   key_ready   : all Nr+1 slots hold the current key's schedule
//   key_clear   : zeroize request (only with AES_KEY_STORE_ZEROIZE_EN)
// Optional feature macro: AES_KEY_STORE_ZEROIZE_EN adds key_clear and makes
// reset wipe the slots as well.
module aes_key_store
    import aes_key_store_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             key_en,
    input  logic [KEY_S-1:0] key,
    input  logic [Nk-1:0]    round_no,
    output logic [KEY_S-1:0] round_key,
    output logic             busy,
    output logic             key_ready
`ifdef AES_KEY_STORE_ZEROIZE_EN
    ,
    input  logic             key_clear
`endif
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_EXPAND = 1'b1;

    logic [0:0]       state;
    logic [Nk-1:0]    cnt;
    logic [KEY_S-1:0] prev;
    logic [KEY_S-1:0] nxt;
    logic [KEY_S-1:0] slot [0:Nr];
    logic             wipe;
    logic             start;

`ifdef AES_KEY_STORE_ZEROIZE_EN
    assign wipe = reset | key_clear;
`else
    assign wipe = reset;
`endif

    assign start = (state == S_IDLE) && key_en;
    assign busy  = (state == S_EXPAND);

    // cnt is 1-based while expanding, so the step constant is rcon[cnt-1].
    aes_key_round u_key_round (
        .prev_key (prev),
        .rcon     (get_rcon(cnt - 1'b1)),
        .next_key (nxt)
    );

    // Control path.
    always_ff @(posedge clk) begin
        if (wipe) begin
            state     <= S_IDLE;
            cnt       <= '0;
            key_ready <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_en) begin
                        state     <= S_EXPAND;
                        cnt       <= 1;
                        key_ready <= 1'b0;
                    end
                end
                default: begin
                    if (cnt == LAST_RND) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        key_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Key storage: only the zeroize build clears slots; otherwise they
    // survive reset and are simply not written while reset is held.
    always_ff @(posedge clk) begin
`ifdef AES_KEY_STORE_ZEROIZE_EN
        if (wipe) begin
            prev <= '0;
            for (int i = 0; i <= Nr; i++)
                slot[i] <= '0;
        end else
`endif
        if (!reset) begin
            if (start) begin
                slot[0] <= key;
                prev    <= key;
            end else if (state == S_EXPAND) begin
                slot[cnt] <= nxt;
                prev      <= nxt;
            end
        end
    end

    // Read port: samples the slot before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (wipe)
            round_key <= '0;
        else if (round_no > LAST_RND)
            round_key <= '0;
        else
            round_key <= slot[round_no];
    end

endmodule

// File: tb/tb_aes_key_store.sv
// Testbench for aes_key_store: FIPS-197 vector, random keys against a
// word-oriented key-schedule model with an S-box derived from GF(2^8).
module tb_aes_key_store;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_en;
    logic [127:0] key;
    logic [3:0]   round_no;
    logic [127:0] round_key;
    logic         busy;
    logic         key_ready;
`ifdef AES_KEY_STORE_ZEROIZE_EN
    logic         key_clear;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] exp_ks [0:10];
    logic [127:0] old_ks [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_key_store dut (
        .clk       (clk),
        .reset     (reset),
        .key_en    (key_en),
        .key       (key),
        .round_no  (round_no),
        .round_key (round_key),
        .busy      (busy),
        .key_ready (key_ready)
`ifdef AES_KEY_STORE_ZEROIZE_EN
        ,
        .key_clear (key_clear)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] model_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {model_sbox(t[31:24]), model_sbox(t[23:16]),
                     model_sbox(t[15:8]), model_sbox(t[7:0])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            exp_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (start and end just after a negedge) ----
    task automatic start_key(input logic [127:0] k);
        key_en = 1'b1;
        key    = k;
        @(posedge clk);
        @(negedge clk);
        key_en = 1'b0;
        key    = rand_key();
    endtask

    // Cycles until key_ready is seen; -1 if it never rises within the bound.
    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (key_ready) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic read_slot(input logic [3:0] r, output logic [127:0] v);
        round_no = r;
        @(posedge clk);
        @(negedge clk);
        v = round_key;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; key_en = 1'b0; key = '0; round_no = '0;
`ifdef AES_KEY_STORE_ZEROIZE_EN
        key_clear = 1'b0;
`endif
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, key_ready} !== 2'b00) begin
            n_bad++; $display("FAIL reset_flags: got busy=%b key_ready=%b, want 0 0", busy, key_ready);
        end
        n_cmp++;
        if (round_key !== '0) begin
            n_bad++; $display("FAIL reset_round_key: got %h, want 0", round_key);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips();
        int n;
        logic [127:0] v;
        model_expand(FIPS_KEY);
        start_key(FIPS_KEY);
        n_cmp++;
        if (busy !== 1'b1 || key_ready !== 1'b0) begin
            n_bad++; $display("FAIL fips_busy: got busy=%b key_ready=%b, want 1 0", busy, key_ready);
        end
        wait_ready(n);
        n_cmp++;
        if (n !== 10) begin
            n_bad++; $display("FAIL fips_latency: got %0d cycles, want 10", n);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL fips_busy_done: got %b, want 0", busy);
        end
        read_slot(4'd1, v);
        n_cmp++;
        if (v !== FIPS_R1) begin
            n_bad++; $display("FAIL fips_round1: got %h, want %h", v, FIPS_R1);
        end
        read_slot(4'd10, v);
        n_cmp++;
        if (v !== FIPS_R10) begin
            n_bad++; $display("FAIL fips_round10: got %h, want %h", v, FIPS_R10);
        end
        read_slot(4'd0, v);
        n_cmp++;
        if (v !== FIPS_KEY) begin
            n_bad++; $display("FAIL fips_round0: got %h, want %h", v, FIPS_KEY);
        end
    endtask

    // round_no 10..0 on consecutive cycles, each checked one cycle later.
    task automatic test_sweep(input string tag);
        for (int r = 10; r >= 0; r--) begin
            round_no = 4'(r);
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (round_key !== exp_ks[r]) begin
                n_bad++; $display("FAIL %s_sweep_r%0d: got %h, want %h", tag, r, round_key, exp_ks[r]);
            end
        end
    endtask

    task automatic test_ignored_key_en();
        int n;
        logic [127:0] v;
        model_expand(FIPS_KEY);
        start_key(FIPS_KEY);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        key_en = 1'b1;
        key    = 128'h000102030405060708090a0b0c0d0e0f;
        @(posedge clk);
        @(negedge clk);
        key_en = 1'b0;
        wait_ready(n);
        n_cmp++;
        if (n !== 6) begin
            n_bad++; $display("FAIL ignored_latency: got %0d remaining cycles, want 6", n);
        end
        read_slot(4'd10, v);
        n_cmp++;
        if (v !== FIPS_R10) begin
            n_bad++; $display("FAIL ignored_round10: got %h, want %h", v, FIPS_R10);
        end
        read_slot(4'd0, v);
        n_cmp++;
        if (v !== FIPS_KEY) begin
            n_bad++; $display("FAIL ignored_round0: got %h, want %h", v, FIPS_KEY);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL ignored_restart: busy got %b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [127:0] k;
        logic [127:0] v;
        round_no = 4'd2;
        start_key(rand_key());
        repeat (4) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, key_ready} !== 2'b00 || round_key !== '0) begin
            n_bad++; $display("FAIL reset_mid: got busy=%b key_ready=%b round_key=%h, want 0 0 0",
                              busy, key_ready, round_key);
        end
        reset = 1'b0;
        @(negedge clk);
        k = rand_key();
        model_expand(k);
        start_key(k);
        wait_ready(n);
        n_cmp++;
        if (n !== 10) begin
            n_bad++; $display("FAIL reset_mid_latency: got %0d cycles, want 10", n);
        end
        test_sweep("post_reset");
        // Slot retention across reset differs by build.
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        read_slot(4'd7, v);
        n_cmp++;
`ifdef AES_KEY_STORE_ZEROIZE_EN
        if (v !== '0) begin
            n_bad++; $display("FAIL reset_zeroize: got %h, want 0", v);
        end
`else
        if (v !== exp_ks[7]) begin
            n_bad++; $display("FAIL reset_retain: got %h, want %h", v, exp_ks[7]);
        end
`endif
    endtask

    task automatic test_out_of_range();
        logic [127:0] v;
        for (int r = 11; r <= 15; r++) begin
            read_slot(4'(r), v);
            n_cmp++;
            if (v !== '0) begin
                n_bad++; $display("FAIL out_of_range_r%0d: got %h, want 0", r, v);
            end
        end
    endtask

    task automatic test_random_keys();
        int n;
        logic [127:0] k;
        for (int t = 0; t < 4; t++) begin
            k = rand_key();
            model_expand(k);
            start_key(k);
            wait_ready(n);
            n_cmp++;
            if (n !== 10) begin
                n_bad++; $display("FAIL random%0d_latency: got %0d cycles, want 10", t, n);
            end
            test_sweep($sformatf("random%0d", t));
        end
    endtask

    // Re-key from a ready state, plus same-edge read-before-write on slot 3.
    task automatic test_rekey();
        int n;
        logic [127:0] k;
        for (int r = 0; r <= 10; r++) old_ks[r] = exp_ks[r];
        k = rand_key();
        model_expand(k);
        start_key(k);
        n_cmp++;
        if (key_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL rekey_flags: got key_ready=%b busy=%b, want 0 1", key_ready, busy);
        end
        repeat (2) begin @(posedge clk); @(negedge clk); end
        round_no = 4'd3;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (round_key !== old_ks[3]) begin
            n_bad++; $display("FAIL rekey_read_before_write: got %h, want %h", round_key, old_ks[3]);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (round_key !== exp_ks[3]) begin
            n_bad++; $display("FAIL rekey_new_slot3: got %h, want %h", round_key, exp_ks[3]);
        end
        wait_ready(n);
        n_cmp++;
        if (n !== 6) begin
            n_bad++; $display("FAIL rekey_latency: got %0d remaining cycles, want 6", n);
        end
        test_sweep("rekey");
    endtask

`ifdef AES_KEY_STORE_ZEROIZE_EN
    task automatic test_zeroize();
        int n;
        logic [127:0] k;
        k = rand_key();
        model_expand(k);
        start_key(k);
        wait_ready(n);
        key_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_clear = 1'b0;
        n_cmp++;
        if ({busy, key_ready} !== 2'b00 || round_key !== '0) begin
            n_bad++; $display("FAIL zeroize_flags: got busy=%b key_ready=%b round_key=%h, want 0 0 0",
                              busy, key_ready, round_key);
        end
        for (int r = 10; r >= 0; r--) begin
            round_no = 4'(r);
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (round_key !== '0) begin
                n_bad++; $display("FAIL zeroize_r%0d: got %h, want 0", r, round_key);
            end
        end
        // key_clear wins over a simultaneous key_en.
        key_clear = 1'b1;
        start_key(k);
        key_clear = 1'b0;
        n_cmp++;
        if ({busy, key_ready} !== 2'b00) begin
            n_bad++; $display("FAIL zeroize_with_key_en: got busy=%b key_ready=%b, want 0 0", busy, key_ready);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL zeroize_stays_idle: got busy=%b, want 0", busy);
        end
        // key_clear aborts an expansion in progress.
        start_key(k);
        @(posedge clk);
        @(negedge clk);
        key_clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_clear = 1'b0;
        round_no = 4'd0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || round_key !== '0) begin
            n_bad++; $display("FAIL zeroize_mid: got busy=%b slot0=%h, want 0 0", busy, round_key);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fips();
        test_sweep("fips");
        test_ignored_key_en();
        test_reset_mid();
        test_out_of_range();
        test_random_keys();
        test_rekey();
`ifdef AES_KEY_STORE_ZEROIZE_EN
        test_zeroize();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
